// File: rtl/nukv_value_narrower.sv
// Splits length-prefixed values arriving as 512-bit segments into 64-bit output words.
// The 16-bit header at the start of each value sets how many bytes are emitted.
module nukv_value_narrower #(
  parameter int unsigned MEMORY_WIDTH = 512,
  parameter int unsigned OUT_WIDTH    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MEMORY_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic [7:0]              out_keep,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    err_short
);

  typedef enum logic [1:0] {StIdle, StEmit, StFill, StDiscard} state_e;

  state_e                  state_q, state_d;
  logic [MEMORY_WIDTH-1:0] buf_q, buf_d;
  logic [2:0]              lane_q, lane_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    last_q, last_d;
  logic                    err_q, err_d;

  logic [15:0] hdr_len;
  logic        final_word;
  logic        lane_end;
  logic [7:0]  final_keep;

  always_comb begin
    hdr_len    = (in_data[15:0] < 16'd2) ? 16'd2 : in_data[15:0];
    final_word = (cnt_q <= 16'd8);
    lane_end   = (lane_q == 3'd7);
    final_keep = '0;
    for (int i = 0; i < 8; i++) begin
      final_keep[i] = (cnt_q[2:0] == 3'd0) || (i < int'(cnt_q[2:0]));
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    lane_d    = lane_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    err_d     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_keep  = '0;
    out_data  = buf_q[OUT_WIDTH*int'(lane_q) +: OUT_WIDTH];

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_d   = in_data;
          last_d  = in_last;
          cnt_d   = hdr_len;
          lane_d  = 3'd0;
          state_d = StEmit;
        end
      end
      StEmit: begin
        out_valid = 1'b1;
        // A segment marked last that runs out before the length does ends the value early.
        out_last  = final_word || (lane_end && last_q);
        out_keep  = final_word ? final_keep : 8'hFF;
        if (out_ready) begin
          lane_d = lane_q + 3'd1;
          cnt_d  = final_word ? 16'd0 : cnt_q - 16'd8;
          if (final_word) begin
            state_d = last_q ? StIdle : StDiscard;
          end else if (lane_end) begin
            if (last_q) begin
              state_d = StIdle;
              err_d   = 1'b1;
            end else begin
              state_d = StFill;
            end
          end
        end
      end
      StFill: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_d   = in_data;
          last_d  = in_last;
          lane_d  = 3'd0;
          state_d = StEmit;
        end
      end
      StDiscard: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_keep  = '0;
    end
  end

  assign err_short = err_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lane_q  <= 3'd0;
      cnt_q   <= 16'd0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Segment buffer carries no reset; its contents only matter while emitting.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: doc/nukv_value_narrower.md
NUKV_VALUE_NARROWER -- requirements
Module: nukv_value_narrower

Interface
REQ-001 SHALL have parameter MEMORY_WIDTH, default 512, the input segment width in bits (fixed at 512).
REQ-002 SHALL have parameter OUT_WIDTH, default 64, the output word width in bits (fixed at 64, 8 lanes per segment).
REQ-003 SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_data, input, MEMORY_WIDTH, value segment; byte 0 is bits [7:0].
REQ-006 SHALL have ports in_valid (input, 1), in_last (input, 1) and in_ready (output, 1): the segment handshake; in_last marks the final segment of a value.
REQ-007 SHALL have port out_data, output, 64, the current 8-byte lane.
REQ-008 SHALL have port out_keep, output, 8, byte-enable of out_data; bit i qualifies bits [8i+7:8i].
REQ-009 SHALL have ports out_valid (output, 1), out_last (output, 1) and out_ready (input, 1): the output handshake.
REQ-010 SHALL have port err_short, output, 1, a one-cycle pulse when a value ends before its declared length.

Function
REQ-011 SHALL define transfers as valid&ready in the same cycle on each interface.
REQ-012 SHALL read L = in_data[15:0] from the first segment of each value as the total byte count, with the length field included; L<2 is treated as 2.
REQ-013 SHALL emit ceil(L/8) output words per value; word k carries bytes [8k+7:8k] of the value (lane k mod 8 of segment k/8).
REQ-014 SHALL set out_keep=8'hFF on non-final words; on the final word out_keep has the low (L mod 8) bits set, or 8'hFF if L mod 8 = 0.
REQ-015 SHALL assert out_last only on the final output word of a value.
REQ-016 SHALL hold a one-segment buffer, a 3-bit lane index and a 16-bit remaining-byte counter; the counter decrements by 8 per output transfer and saturates at 0.
REQ-017 SHALL implement state ST_IDLE: in_ready=1; on an input transfer, latch the segment, load the counter with L, set lane=0, and go to ST_EMIT.
REQ-018 SHALL implement state ST_EMIT: out_valid=1, out_data=buffer lane; on an output transfer, lane+1 and counter-8.
REQ-019 In ST_EMIT, SHALL go to ST_IDLE when the final word transfers and the buffered segment had in_last=1.
REQ-020 In ST_EMIT, SHALL go to ST_DISCARD when the final word transfers and the buffered segment had in_last=0.
REQ-021 In ST_EMIT, SHALL go to ST_FILL when lane 7 transfers, bytes remain, and the buffered segment had in_last=0.
REQ-022 In ST_EMIT, on a lane-7 transfer with bytes remaining and buffered in_last=1: SHALL treat that word as final (out_last=1, out_keep=8'hFF), pulse err_short the next cycle, and go to ST_IDLE.
REQ-023 SHALL implement state ST_FILL: in_ready=1, out_valid=0; on an input transfer, latch the segment, set lane=0, and go to ST_EMIT; the counter is kept.
REQ-024 SHALL implement state ST_DISCARD: in_ready=1, out_valid=0; input segments are dropped, and an input transfer with in_last=1 goes to ST_IDLE.
REQ-025 SHALL have first-output latency of 1 cycle: out_valid rises the cycle after the header segment transfers.
REQ-026 SHALL keep in_ready=0 in ST_EMIT, and SHALL hold out_data/out_keep/out_last stable while out_valid=1 and out_ready=0.
REQ-027 SHALL support values spanning any number of segments up to L=65535 with no lane or counter wrap errors.

Reset
REQ-028 On rst=1: state=ST_IDLE, lane=0, counter=0, out_valid=0, out_last=0, out_keep=0, err_short=0; in_ready=0 during reset, 1 the cycle after.
REQ-029 Reset mid-value SHALL abandon the value with no further outputs; the next segment accepted is treated as a header.
REQ-030 The buffer contents SHALL NOT be reset; out_data is don't-care while out_valid=0.

Verification
REQ-031 Single segment, L=5, in_last=1 -> exactly 1 output, keep=8'h1F, out_last=1, then return to IDLE.
REQ-032 Segment 1 L=130, followed by segments 2 and 3 (segment 3 in_last=1), out_ready=1 -> 17 outputs; outputs 1-16 keep=FF; output 17 keep=8'h03 with last=1.
REQ-033 L=10 over 3 segments (segment 3 in_last=1) -> 2 outputs (second keep=8'h03, last=1); segments 2 and 3 are consumed with no output.
REQ-034 L=200 with in_last on segment 2 -> 16 outputs, output 16 last=1 keep=FF, err_short pulses once.
REQ-035 L=64, out_ready toggling randomly -> 8 outputs with data matching bytes 0-63; payload held stable under stall; last keep=FF.
REQ-036 rst asserted after 3 outputs of an L=130 value, then a new L=5 value -> 1 output keep=8'h1F last=1; no residue from the old value.
